// File: rtl/dsp_pkg.sv
// Shared constants for the DSP post-adder slice.
// Holds opmode bit positions, X/Z mux select encodings and datapath widths.
package dsp_pkg;

  localparam int P_W = 48;
  localparam int M_W = 36;
  localparam int R_W = 49;
  localparam int OP_W = 8;

  localparam int OP_X_LSB = 0;
  localparam int OP_Z_LSB = 2;
  localparam int OP_CIN = 5;
  localparam int OP_SUB = 7;

  typedef enum logic [1:0] {
    X_ZERO = 2'b00,
    X_M    = 2'b01,
    X_P    = 2'b10,
    X_DAB  = 2'b11
  } x_sel_e;

  typedef enum logic [1:0] {
    Z_ZERO = 2'b00,
    Z_PCIN = 2'b01,
    Z_P    = 2'b10,
    Z_C    = 2'b11
  } z_sel_e;

endpackage

// File: rtl/dsp_pipe_reg.sv
// Optional pipeline register: async active-high clear, clock enable.
// Ports: clk, rst, ce, d (in, width), q (out, width); use=0 is a wire.
module dsp_pipe_reg #(
  parameter int width = 1,
  parameter bit use_reg = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  if (use_reg) begin : g_reg
    logic [width-1:0] r;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r <= '0;
      else if (ce) r <= d;
    end
    assign q = r;
  end else begin : g_wire
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst, ce};
    assign q = d;
  end

endmodule

// File: rtl/dsp_post_adder.sv
// DSP slice post-adder: X/Z muxes, add/subtract with carry, P feedback.
// Ports: clk, rst, ce_* enables, opmode, m_in, dab_in, c_in, pcin,
//        carryin in; p, pcout, carryout, carryoutf out.
module dsp_post_adder
  import dsp_pkg::*;
#(
  parameter int OPMODEREG   = 1,
  parameter int CREG        = 1,
  parameter int CARRYINREG  = 1,
  parameter int PREG        = 1,
  parameter int CARRYOUTREG = 1,
  parameter     CARRYINSEL  = "OPMODE5"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_opmode,
  input  logic        ce_c,
  input  logic        ce_carryin,
  input  logic        ce_p,
  input  logic        ce_carryout,
  input  logic [7:0]  opmode,
  input  logic [35:0] m_in,
  input  logic [47:0] dab_in,
  input  logic [47:0] c_in,
  input  logic [47:0] pcin,
  input  logic        carryin,
  output logic [47:0] p,
  output logic [47:0] pcout,
  output logic        carryout,
  output logic        carryoutf
);

  logic [OP_W-1:0] opm;
  logic [P_W-1:0]  c_q;
  logic            cin_d;
  logic            cin;
  logic [P_W-1:0]  p_q;
  logic [P_W-1:0]  fb;
  logic [P_W-1:0]  x;
  logic [P_W-1:0]  z;
  logic [R_W-1:0]  r;
  logic            co_q;
  logic            unused_op;

  assign unused_op = ^{opm[6], opm[4]};

  // Carry source is taken from the raw inputs so that it shares the
  // opmode pipeline timing when registered.
  if (CARRYINSEL == "CARRYIN") begin : g_cin_ext
    logic unused_cin;
    assign unused_cin = opmode[OP_CIN];
    assign cin_d = carryin;
  end else begin : g_cin_op
    logic unused_cin;
    assign unused_cin = carryin;
    assign cin_d = opmode[OP_CIN];
  end

  dsp_pipe_reg #(.width(OP_W), .use_reg(OPMODEREG != 0)) u_opmode (
    .clk(clk), .rst(rst), .ce(ce_opmode), .d(opmode), .q(opm)
  );

  dsp_pipe_reg #(.width(P_W), .use_reg(CREG != 0)) u_c (
    .clk(clk), .rst(rst), .ce(ce_c), .d(c_in), .q(c_q)
  );

  dsp_pipe_reg #(.width(1), .use_reg(CARRYINREG != 0)) u_cin (
    .clk(clk), .rst(rst), .ce(ce_carryin), .d(cin_d), .q(cin)
  );

  // Without a P register the feedback path is tied off to break the loop.
  if (PREG != 0) begin : g_fb
    assign fb = p_q;
  end else begin : g_nofb
    assign fb = '0;
  end

  always_comb begin
    x = '0;
    unique case (x_sel_e'(opm[OP_X_LSB +: 2]))
      X_ZERO: x = '0;
      X_M:    x = {{(P_W-M_W){1'b0}}, m_in};
      X_P:    x = fb;
      X_DAB:  x = dab_in;
      default: x = '0;
    endcase
  end

  always_comb begin
    z = '0;
    unique case (z_sel_e'(opm[OP_Z_LSB +: 2]))
      Z_ZERO: z = '0;
      Z_PCIN: z = pcin;
      Z_P:    z = fb;
      Z_C:    z = c_q;
      default: z = '0;
    endcase
  end

  // 49-bit arithmetic: bit 48 is carry on add, borrow on subtract.
  always_comb begin
    r = '0;
    if (opm[OP_SUB])
      r = {1'b0, z} - ({1'b0, x} + {{(R_W-1){1'b0}}, cin});
    else
      r = {1'b0, z} + {1'b0, x} + {{(R_W-1){1'b0}}, cin};
  end

  dsp_pipe_reg #(.width(P_W), .use_reg(PREG != 0)) u_p (
    .clk(clk), .rst(rst), .ce(ce_p), .d(r[P_W-1:0]), .q(p_q)
  );

  dsp_pipe_reg #(.width(1), .use_reg(CARRYOUTREG != 0)) u_co (
    .clk(clk), .rst(rst), .ce(ce_carryout), .d(r[R_W-1]), .q(co_q)
  );

  assign p         = p_q;
  assign pcout     = p_q;
  assign carryout  = co_q;
  assign carryoutf = co_q;

endmodule

// File: tb/tb_dsp_post_adder.sv
// Directed bench for dsp_post_adder: registered, ext-carry, bypass builds.
// Drives after negedge, samples at the following negedge.
module tb_dsp_post_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_opmode, ce_c, ce_carryin, ce_p, ce_carryout;
  logic [7:0]  opmode;
  logic [35:0] m_in;
  logic [47:0] dab_in, c_in, pcin;
  logic        carryin;

  logic [47:0] p0, pc0, p1, pc1, p2, pc2;
  logic        co0, cf0, co1, cf1, co2, cf2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dsp_post_adder u0 (
    .clk(clk), .rst(rst),
    .ce_opmode(ce_opmode), .ce_c(ce_c), .ce_carryin(ce_carryin),
    .ce_p(ce_p), .ce_carryout(ce_carryout),
    .opmode(opmode), .m_in(m_in), .dab_in(dab_in), .c_in(c_in),
    .pcin(pcin), .carryin(carryin),
    .p(p0), .pcout(pc0), .carryout(co0), .carryoutf(cf0)
  );

  dsp_post_adder #(.CARRYINSEL("CARRYIN")) u1 (
    .clk(clk), .rst(rst),
    .ce_opmode(ce_opmode), .ce_c(ce_c), .ce_carryin(ce_carryin),
    .ce_p(ce_p), .ce_carryout(ce_carryout),
    .opmode(opmode), .m_in(m_in), .dab_in(dab_in), .c_in(c_in),
    .pcin(pcin), .carryin(carryin),
    .p(p1), .pcout(pc1), .carryout(co1), .carryoutf(cf1)
  );

  dsp_post_adder #(
    .OPMODEREG(0), .CREG(0), .CARRYINREG(0),
    .PREG(0), .CARRYOUTREG(0)
  ) u2 (
    .clk(clk), .rst(rst),
    .ce_opmode(ce_opmode), .ce_c(ce_c), .ce_carryin(ce_carryin),
    .ce_p(ce_p), .ce_carryout(ce_carryout),
    .opmode(opmode), .m_in(m_in), .dab_in(dab_in), .c_in(c_in),
    .pcin(pcin), .carryin(carryin),
    .p(p2), .pcout(pc2), .carryout(co2), .carryoutf(cf2)
  );

  task automatic chk(input string tag, input logic [48:0] got,
                     input logic [48:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    {ce_opmode, ce_c, ce_carryin, ce_p, ce_carryout} = 5'b11111;
    opmode = 8'h00;
    m_in = '0;
    dab_in = '0;
    c_in = '0;
    pcin = '0;
    carryin = 1'b0;
    #2;
    chk("rst_p", {1'b0, p0}, 49'd0);
    chk("rst_co", {48'd0, co0}, 49'd0);
    step();
    step();
    chk("rst_pcout", {1'b0, pc0}, 49'd0);
    rst = 1'b0;

    // multiply-accumulate: Z=P, X=M
    opmode = 8'b0000_1001;
    m_in = 36'd100;
    step();
    chk("mac_first", {1'b0, p0}, 49'd0);
    step();
    chk("mac_100", {1'b0, p0}, 49'd100);
    step();
    chk("mac_200", {1'b0, p0}, 49'd200);
    step();
    chk("mac_300", {1'b0, p0}, 49'd300);

    // async reset between edges
    #1 rst = 1'b1;
    #1 chk("arst_p", {1'b0, p0}, 49'd0);
    #1 rst = 1'b0;
    step();
    chk("restart_0", {1'b0, p0}, 49'd0);
    step();
    chk("restart_100", {1'b0, p0}, 49'd100);
    step();
    step();
    step();
    chk("mac_400", {1'b0, p0}, 49'd400);
    chk("mac_co", {48'd0, co0}, 49'd0);

    ce_p = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_p", {1'b0, p0}, 49'd400);
    end
    ce_p = 1'b1;

    // wrap-around: C + dab
    opmode = 8'b0000_1111;
    c_in = 48'hFFFF_FFFF_FFFF;
    dab_in = 48'd1;
    step();
    step();
    chk("wrap_p", {1'b0, p0}, 49'd0);
    chk("wrap_co", {48'd0, co0}, 49'd1);
    chk("wrap_pcout", {1'b0, pc0}, 49'd0);
    chk("wrap_cof", {48'd0, cf0}, 49'd1);

    // subtract with borrow: 5 - 7
    opmode = 8'b1000_1111;
    c_in = 48'd5;
    dab_in = 48'd7;
    step();
    step();
    chk("sub_p", {1'b0, p0}, {1'b0, 48'hFFFF_FFFF_FFFE});
    chk("sub_co", {48'd0, co0}, 49'd1);

    // carry-in from opmode[5]
    opmode = 8'b0010_0000;
    step();
    step();
    chk("cin_op5_p", {1'b0, p0}, 49'd1);
    chk("cin_op5_co", {48'd0, co0}, 49'd0);

    // external carry-in on u1, opmode[5]=0 on u0
    opmode = 8'b0000_0001;
    m_in = '0;
    carryin = 1'b1;
    step();
    step();
    chk("cin_ext_p", {1'b0, p1}, 49'd1);
    chk("cin_op5_zero", {1'b0, p0}, 49'd0);
    carryin = 1'b0;

    // fully bypassed build: P selections read as 0
    opmode = 8'b0000_1011;
    dab_in = 48'd123;
    #1 chk("byp_zp", {1'b0, p2}, 49'd123);
    opmode = 8'b0000_1110;
    c_in = 48'd77;
    #1 chk("byp_xp", {1'b0, p2}, 49'd77);
    opmode = 8'b1000_1111;
    c_in = 48'd5;
    dab_in = 48'd7;
    #1 chk("byp_sub_p", {1'b0, p2}, {1'b0, 48'hFFFF_FFFF_FFFE});
    chk("byp_sub_co", {48'd0, cf2}, 49'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dsp_post_adder.md
DSP_POST_ADDER -- requirements
Module: dsp_post_adder

Interface
REQ-001 Parameter OPMODEREG, default 1, SHALL set whether the opmode register is used (1) or bypassed (0).
REQ-002 Parameter CREG, default 1, SHALL set whether the C operand register is used (1) or bypassed (0).
REQ-003 Parameter CARRYINREG, default 1, SHALL set whether the carry-in register is used (1) or bypassed (0).
REQ-004 Parameter PREG, default 1, SHALL set whether the P output register is used (1) or bypassed (0).
REQ-005 Parameter CARRYOUTREG, default 1, SHALL set whether the carry-out register is used (1) or bypassed (0).
REQ-006 Parameter CARRYINSEL, default "OPMODE5", SHALL select the carry-in source: "OPMODE5" uses opmode[5]; "CARRYIN" uses port carryin.
REQ-007 Ports (name direction width meaning):
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- ce_opmode, ce_c, ce_carryin, ce_p, ce_carryout  in  1 each  clock enables for the matching register.
- opmode  in  8  [1:0] X select, [3:2] Z select, [5] carry-in value, [7] subtract; bits 4 and 6 ignored.
- m_in  in  36  product from the upstream multiplier register stage.
- dab_in  in  48  concatenation {D[11:0],A[17:0],B[17:0]}.
- c_in  in  48  C operand.
- pcin  in  48  cascade input from the previous slice.
- carryin  in  1  external carry-in.
- p  out  48  result.
- pcout  out  48  cascade output, always equal to p.
- carryout  out  1  carry/borrow out.
- carryoutf  out  1  fabric copy, always equal to carryout.

Function
REQ-008 Each *REG=1 register SHALL load its input on rising clk when its CE is 1, and hold otherwise; each *REG=0 path SHALL be combinational pass-through.
REQ-009 X mux SHALL select by registered/bypassed opmode[1:0]: 00 → 0, 01 → zero-extended m_in, 10 → P, 11 → dab_in.
REQ-010 Z mux SHALL select by opmode[3:2]: 00 → 0, 01 → pcin, 10 → P, 11 → C.
REQ-011 With PREG=0, any X or Z selection of P SHALL yield 0, so no combinational loop exists.
REQ-012 Post-adder SHALL compute a 49-bit result R = Z + X + CIN when opmode[7]=0, and R = Z − (X + CIN) when opmode[7]=1; operands are zero-extended to 49 bits.
REQ-013 P input SHALL be R[47:0] (modulo 2^48 wrap-around); carry-out input SHALL be R[48] (carry for add, borrow for subtract).
REQ-014 With all registers enabled and all CEs 1, p SHALL reflect m_in/dab_in/pcin one cycle after they are presented, and opmode/c_in/carryin two cycles after they are presented.
REQ-015 Accumulate (Z=P or X=P, PREG=1) SHALL use the P value held before the current edge; with ce_p=0, p and the feedback SHALL hold.
REQ-016 With every register bypassed, the block SHALL be purely combinational from all inputs to p/carryout.

Reset
REQ-017 rst=1 SHALL asynchronously clear every internal register (opmode, C, carry-in, P, carry-out) to 0, regardless of CE.
REQ-018 During and after reset, with PREG=1 and CARRYOUTREG=1, p, pcout, carryout and carryoutf SHALL read 0 until the first enabled edge after rst falls.
REQ-019 Reset asserted mid-accumulation SHALL discard the accumulated value; accumulation SHALL restart from 0.

Structure
REQ-020 Shared package dsp_pkg SHALL hold the opmode bit positions, X/Z select encodings, and width constants (48, 36, 49).
REQ-021 The block SHALL instantiate one sub-module, dsp_pipe_reg (parameter width, use flag; ports clk, rst, ce, d, q), for each of the five optional registers.

Verification
REQ-022 Multiply-accumulate: PREG=1, opmode=8'b0000_1001 (Z=P, X=M), m_in=100 for 4 cycles → p sequence 100, 200, 300, 400; carryout 0 throughout.
REQ-023 Wrap-around: C=48'hFFFF_FFFF_FFFF, X=dab_in=1, add → p=0, carryout=1.
REQ-024 Subtract with borrow: Z=C=5, X=dab_in=7, opmode[7]=1 → p=48'hFFFF_FFFF_FFFE, carryout=1.
REQ-025 Carry-in source: CARRYINSEL="CARRYIN", carryin=1, Z=0, X=M=0 → p=1; same with "OPMODE5" and opmode[5]=0 → p=0.
REQ-026 Async reset mid-accumulate: assert rst between clk edges while p=300 → p=0 immediately; CE hold with ce_p=0 → p unchanged across 3 edges.
REQ-027 Bypass: all *REG=0 and X or Z selecting P → p equals the other operand (P treated as 0), with no combinational loop.
